// File: rtl/wb_ram_arb_2_pkg.sv
// Shared Wishbone arbiter constants: grant-state encodings and watchdog counter sizing.
package wb_ram_arb_2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Counter must hold 0..timeout; a disabled watchdog still needs a legal 1-bit width.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Slave no-ack watchdog: counts strobed cycles without ack and raises a one-cycle hit.
module wb_watchdog
    import wb_ram_arb_2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic restart,
    output logic hit
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign hit = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = wdog_width(TIMEOUT);

            logic [CW-1:0] count;
            logic [CW-1:0] limit;
            logic          fire;

            assign limit = CW'(TIMEOUT - 1);
            // An ack in the limit cycle suppresses the hit, so ack always wins.
            assign fire  = stb && !ack && !restart && (count == limit);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                    hit   <= 1'b0;
                end else begin
                    hit <= fire;
                    if (ack || !stb || restart || fire) begin
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wb_ram_arb_2.sv
// Two-master round-robin Wishbone arbiter in front of a shared RAM slave, with no-ack watchdog.
module wb_ram_arb_2
    import wb_ram_arb_2_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    input  logic                    wbm0_cyc_i,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    input  logic                    wbm1_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    output logic                    wbs_cyc_o
);

    arb_state_t state;
    arb_state_t next_state;
    arb_state_t pick;
    logic       last_gnt;
    logic       hit;
    logic       restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= next_state;
            if (restart) begin
                if (next_state == GNT0) begin
                    last_gnt <= 1'b0;
                end else if (next_state == GNT1) begin
                    last_gnt <= 1'b1;
                end
            end
        end
    end

    // Re-arbitration happens in the same edge the owner drops cyc, so handover has no idle cycle.
    always_comb begin
        pick = IDLE;
        if (wbm0_cyc_i && wbm1_cyc_i) begin
            pick = last_gnt ? GNT0 : GNT1;
        end else if (wbm0_cyc_i) begin
            pick = GNT0;
        end else if (wbm1_cyc_i) begin
            pick = GNT1;
        end

        next_state = pick;
        case (state)
            GNT0:    if (wbm0_cyc_i) next_state = GNT0;
            GNT1:    if (wbm1_cyc_i) next_state = GNT1;
            default: ;
        endcase
    end

    assign restart = (next_state != state);

    always_comb begin
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_sel_o  = '0;
        wbs_stb_o  = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbm0_dat_o = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm1_dat_o = '0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        case (state)
            GNT0: begin
                wbs_adr_o  = wbm0_adr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_we_o   = wbm0_we_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_stb_o  = wbm0_stb_i & ~hit;
                wbs_cyc_o  = wbm0_cyc_i;
                wbm0_dat_o = wbs_dat_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = hit & ~wbs_ack_i;
            end
            GNT1: begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_we_o   = wbm1_we_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_stb_o  = wbm1_stb_i & ~hit;
                wbs_cyc_o  = wbm1_cyc_i;
                wbm1_dat_o = wbs_dat_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = hit & ~wbs_ack_i;
            end
            default: ;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .stb    (wbs_stb_o),
        .ack    (wbs_ack_i),
        .restart(restart),
        .hit    (hit)
    );

endmodule

// File: tb/tb_wb_ram_arb_2.sv
// Bench for wb_ram_arb_2: behavioural RAM slave, word-array memory model and round-robin grant model.
module tb_wb_ram_arb_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic [31:0] m_rdat[2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_stb [2];
    logic        m_ack [2];
    logic        m_err [2];
    logic        m_cyc [2];
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic        s_we, s_stb, s_ack, s_cyc;
    logic [3:0]  s_sel;

    always #5 clk = ~clk;

    wb_ram_arb_2 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_wdat[0]), .wbm0_dat_o(m_rdat[0]),
        .wbm0_we_i (m_we[0]),  .wbm0_sel_i(m_sel[0]),  .wbm0_stb_i(m_stb[0]),
        .wbm0_ack_o(m_ack[0]), .wbm0_err_o(m_err[0]),  .wbm0_cyc_i(m_cyc[0]),
        .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_wdat[1]), .wbm1_dat_o(m_rdat[1]),
        .wbm1_we_i (m_we[1]),  .wbm1_sel_i(m_sel[1]),  .wbm1_stb_i(m_stb[1]),
        .wbm1_ack_o(m_ack[1]), .wbm1_err_o(m_err[1]),  .wbm1_cyc_i(m_cyc[1]),
        .wbs_adr_o (s_adr),    .wbs_dat_i (s_rdat),    .wbs_dat_o (s_wdat),
        .wbs_we_o  (s_we),     .wbs_sel_o (s_sel),     .wbs_stb_o (s_stb),
        .wbs_ack_i (s_ack),    .wbs_cyc_o (s_cyc)
    );

    // Single-cycle RAM: acks every other cycle while strobed, ack can be muted for the watchdog test.
    logic [31:0] ram [0:255];
    logic        ack_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_rdat <= '0;
        end else begin
            s_ack <= ack_en && s_cyc && s_stb && !s_ack;
            if (s_cyc && s_stb && !s_ack) begin
                s_rdat <= ram[s_adr[9:2]];
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) ram[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
                end
            end
        end
    end

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [31:0] model [16];
    int          last_tb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        m_adr[m] = adr; m_wdat[m] = dat; m_we[m] = we; m_sel[m] = sel;
        m_stb[m] = 1'b1; m_cyc[m] = 1'b1;
    endtask

    task automatic release_m(input int m);
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output int lat, output logic err);
        logic got;
        @(negedge clk);
        drive(m, we, adr, dat, sel);
        lat = 0; rdat = '0; err = 1'b0; got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (m_ack[m] || m_err[m]) begin
                got  = 1'b1;
                rdat = m_rdat[m];
                err  = m_err[m];
            end
        end
        release_m(m);
        chk("xfer_bounded", 64'(got), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_cyc"}, 64'(s_cyc), 64'd0);
        chk({tag, "_s_stb"}, 64'(s_stb), 64'd0);
        chk({tag, "_s_bus"}, 64'({s_adr, s_wdat}), 64'd0);
        chk({tag, "_s_we_sel"}, 64'({s_we, s_sel}), 64'd0);
        chk({tag, "_m_resp"}, 64'({m_ack[0], m_err[0], m_ack[1], m_err[1]}), 64'd0);
        chk({tag, "_m_rdat"}, 64'({m_rdat[0], m_rdat[1]}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    logic [31:0] rd  [2];
    int          lat [2];
    logic        err [2];
    logic        op_we [2];
    int          op_idx[2];
    logic [31:0] op_dat[2];
    logic [3:0]  op_sel[2];
    logic [31:0] bdat  [4];
    int          beats, cyc_n, w;

    initial begin
        rst_n  = 1'b0;
        ack_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_wdat[m] = '0; m_we[m] = 1'b0; m_sel[m] = '0;
            m_stb[m] = 1'b0; m_cyc[m] = 1'b0;
        end
        last_tb = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Prefill every model word with full-word writes from alternating masters.
        for (int i = 0; i < 16; i++) begin
            op_dat[0] = $urandom;
            xfer(i % 2, 1'b1, 32'(i) << 2, op_dat[0], 4'hF, rd[0], lat[0], err[0]);
            model[i] = op_dat[0];
            last_tb  = i % 2;
            chk("prefill_lat", 64'(lat[0]), 64'd2);
        end

        // Simultaneous requests: round-robin from the last grant, handover without idle cycle.
        @(negedge clk);
        w = (last_tb == 1) ? 0 : 1;
        drive(0, 1'b1, 32'h20, 32'hA5A5_0001, 4'hF);
        drive(1, 1'b1, 32'h24, 32'h5A5A_0002, 4'hF);
        @(negedge clk);
        chk("coll1_first_adr", 64'(s_adr), (w == 0) ? 64'h20 : 64'h24);
        @(negedge clk);
        chk("coll1_first_ack", 64'({m_ack[w], m_ack[1-w]}), 64'b10);
        release_m(w);
        @(negedge clk);
        chk("coll1_second_adr", 64'(s_adr), (w == 0) ? 64'h24 : 64'h20);
        @(negedge clk);
        chk("coll1_second_ack", 64'({m_ack[1-w], m_ack[w]}), 64'b10);
        release_m(1 - w);
        model[8] = 32'hA5A5_0001;
        model[9] = 32'h5A5A_0002;
        last_tb  = 1 - w;
        @(negedge clk);
        w = (last_tb == 1) ? 0 : 1;
        drive(0, 1'b0, 32'h20, '0, 4'hF);
        drive(1, 1'b0, 32'h24, '0, 4'hF);
        @(negedge clk);
        chk("coll2_first_adr", 64'(s_adr), (w == 0) ? 64'h20 : 64'h24);
        @(negedge clk);
        chk("coll2_first_rdat", 64'(m_rdat[w]), 64'(model[8 + w]));
        release_m(w);
        repeat (2) @(negedge clk);
        chk("coll2_second_rdat", 64'({m_ack[1-w], m_rdat[1-w]}), {31'd0, 1'b1, model[9 - w]});
        release_m(1 - w);
        last_tb = 1 - w;

        // Directed write then cross-master read.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd[0], lat[0], err[0]);
        model[4] = 32'hDEADBEEF;
        chk("dead_wr_lat", 64'(lat[0]), 64'd2);
        xfer(1, 1'b0, 32'h10, '0, 4'hF, rd[1], lat[1], err[1]);
        chk("dead_rd_lat", 64'(lat[1]), 64'd2);
        chk("dead_rd_data", 64'(rd[1]), 64'hDEADBEEF);
        last_tb = 1;

        // Four-beat master 0 cycle with master 1 arriving mid-cycle: no preemption, no strobe gap.
        for (int i = 0; i < 4; i++) bdat[i] = $urandom;
        @(negedge clk);
        drive(0, 1'b1, 32'(10) << 2, bdat[0], 4'hF);
        beats = 0; cyc_n = 0;
        while (beats < 4 && cyc_n < 40) begin
            @(negedge clk);
            cyc_n++;
            chk("burst_stb", 64'(s_stb), 64'd1);
            chk("burst_m1_ack", 64'(m_ack[1]), 64'd0);
            if (m_ack[0]) begin
                model[10 + beats] = bdat[beats];
                beats++;
                if (beats == 4) release_m(0);
                else begin
                    m_adr[0]  = 32'(10 + beats) << 2;
                    m_wdat[0] = bdat[beats];
                end
            end
            if (cyc_n == 3) drive(1, 1'b0, 32'(10) << 2, '0, 4'hF);
        end
        chk("burst_len", 64'(cyc_n), 64'd8);
        lat[1] = 0;
        while (!m_ack[1] && lat[1] < 20) begin
            @(negedge clk);
            lat[1]++;
        end
        chk("burst_m1_wait", 64'(lat[1]), 64'd2);
        chk("burst_m1_rdat", 64'(m_rdat[1]), 64'(model[10]));
        release_m(1);
        last_tb = 1;

        // Randomized single and colliding transfers against the memory and grant models.
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 2; m++) begin
                op_we[m]  = 1'($urandom_range(0, 1));
                op_idx[m] = $urandom_range(0, 15);
                op_dat[m] = $urandom;
                op_sel[m] = op_we[m] ? 4'($urandom_range(1, 15)) : 4'hF;
            end
            if ($urandom_range(0, 2) == 0) begin
                w = (last_tb == 1) ? 0 : 1;
                fork
                    xfer(0, op_we[0], 32'(op_idx[0]) << 2, op_dat[0], op_sel[0], rd[0], lat[0], err[0]);
                    xfer(1, op_we[1], 32'(op_idx[1]) << 2, op_dat[1], op_sel[1], rd[1], lat[1], err[1]);
                join
                chk("rnd_coll_win_lat", 64'(lat[w]), 64'd2);
                chk("rnd_coll_lose_lat", 64'(lat[1-w]), 64'd4);
                for (int k = 0; k < 2; k++) begin
                    int m;
                    m = (k == 0) ? w : 1 - w;
                    chk("rnd_coll_err", 64'(err[m]), 64'd0);
                    if (op_we[m]) model[op_idx[m]] = merge(model[op_idx[m]], op_dat[m], op_sel[m]);
                    else chk("rnd_coll_rdat", 64'(rd[m]), 64'(model[op_idx[m]]));
                end
                last_tb = 1 - w;
            end else begin
                w = $urandom_range(0, 1);
                xfer(w, op_we[w], 32'(op_idx[w]) << 2, op_dat[w], op_sel[w], rd[w], lat[w], err[w]);
                chk("rnd_lat", 64'(lat[w]), 64'd2);
                chk("rnd_err", 64'(err[w]), 64'd0);
                if (op_we[w]) model[op_idx[w]] = merge(model[op_idx[w]], op_dat[w], op_sel[w]);
                else chk("rnd_rdat", 64'(rd[w]), 64'(model[op_idx[w]]));
                last_tb = w;
            end
        end

        // Watchdog: slave never acks, error pulse four cycles after strobe rises.
        @(negedge clk);
        ack_en = 1'b0;
        drive(0, 1'b0, 32'h0, '0, 4'hF);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("wdog_stb", 64'(s_stb), (i == 5) ? 64'd0 : 64'd1);
            chk("wdog_err0", 64'(m_err[0]), (i == 5) ? 64'd1 : 64'd0);
            chk("wdog_other", 64'({m_ack[0], m_ack[1], m_err[1]}), 64'd0);
        end
        release_m(0);
        @(negedge clk);
        ack_en = 1'b1;
        chk("wdog_after", 64'({m_err[0], s_stb}), 64'd0);
        last_tb = 0;

        // Asynchronous reset in the middle of a write.
        @(negedge clk);
        drive(0, 1'b1, 32'(2) << 2, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("rst_mid_active", 64'({s_cyc, s_stb}), 64'b11);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        release_m(0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'(2) << 2, '0, 4'hF, rd[1], lat[1], err[1]);
        chk("post_rst_lat", 64'(lat[1]), 64'd2);
        chk("post_rst_rdat", 64'(rd[1]), 64'(model[2]));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
